// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage: issues word fetches over a req/ready
// handshake, fills the IF/ID register, and absorbs decode stalls and branch redirects.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | out of reset, no request issued yet
//   REQ   | request outstanding at pc; accepts a response whenever ready=1
//   HOLD  | response parked in the hold buffer while decode is stalled
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_INC    = 16'd2,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch,
  input  logic        pcsrc,
  input  logic [15:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic [15:0] pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] if_instr_nxt, if_pc_nxt;
  logic        if_valid_nxt;
  logic [15:0] hold_instr, hold_instr_nxt;
  logic [15:0] hold_pc, hold_pc_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic        redirect;
  logic [15:0] pc_seq;
  logic [15:0] target_aligned;
  logic        unused_target_lsb;

  // pcsrc is only meaningful with a branch in decode; a stale pcsrc must not redirect
  assign redirect          = branch & ~pcsrc;
  assign pc_seq            = pc + PC_INC;
  assign target_aligned    = {branch_target[15:1], 1'b0};
  assign unused_target_lsb = branch_target[0];

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      if_instr   <= NOP_INSTR;
      if_pc      <= 16'h0000;
      if_valid   <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 16'h0000;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      if_instr   <= if_instr_nxt;
      if_pc      <= if_pc_nxt;
      if_valid   <= if_valid_nxt;
      hold_instr <= hold_instr_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_valid <= hold_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    if_instr_nxt   = if_instr;
    if_pc_nxt      = if_pc;
    if_valid_nxt   = if_valid;
    hold_instr_nxt = hold_instr;
    hold_pc_nxt    = hold_pc;
    hold_valid_nxt = hold_valid;

    if (redirect) begin
      // any response landing this cycle belongs to the wrong path and is dropped
      pc_nxt         = target_aligned;
      if_instr_nxt   = NOP_INSTR;
      if_valid_nxt   = 1'b0;
      hold_valid_nxt = 1'b0;
      state_nxt      = ST_REQ;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (!stall) begin
            if (imem_ready) begin
              if_instr_nxt = imem_rdata;
              if_pc_nxt    = pc;
              if_valid_nxt = 1'b1;
              pc_nxt       = pc_seq;
            end else begin
              if_instr_nxt = NOP_INSTR;
              if_valid_nxt = 1'b0;
            end
          end else if (imem_ready) begin
            hold_instr_nxt = imem_rdata;
            hold_pc_nxt    = pc;
            hold_valid_nxt = 1'b1;
            pc_nxt         = pc_seq;
            state_nxt      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            if_instr_nxt   = hold_instr;
            if_pc_nxt      = hold_pc;
            if_valid_nxt   = hold_valid;
            hold_valid_nxt = 1'b0;
            state_nxt      = ST_REQ;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage for the 16-bit datapath; consumes the branch unit's PCSRC decision and branch target. Holds the PC and issues word requests to instruction memory over a req/ready handshake. Delivers instructions into the IF/ID register with a valid flag. Handles decode stalls with a one-entry hold buffer and flushes on a taken branch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, sequential increment (16-bit instructions, byte-addressed)
NOP_INSTR, 16'h0000, encoding placed in if_instr on flush/bubble

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
branch  input  1  branch instruction in decode; qualifies pcsrc
pcsrc  input  1  branch unit decision: 0 = take branch_target, 1 = sequential
branch_target  input  16  redirect address
stall  input  1  decode cannot accept a new instruction this cycle
imem_req  output  1  fetch request to instruction memory
imem_addr  output  16  fetch address
imem_ready  input  1  imem_rdata valid; completes the current request
imem_rdata  input  16  fetched instruction word
if_instr  output  16  IF/ID instruction register
if_pc  output  16  address of if_instr
if_valid  output  1  if_instr is a real instruction
pc  output  16  current fetch PC

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous, active-low. Reset mid-operation aborts everything, with no completion of an in-flight request.
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_instr=NOP_INSTR, if_pc=16'h0000, if_valid=0, hold buffer empty, state IDLE.
- redirect = branch & ~pcsrc. It is combinational from inputs and sampled on the clock edge.
- IDLE: imem_req=0. Goes to REQ unconditionally on the first clock edge after reset_n deasserts.
- REQ:
  - imem_req=1 and imem_addr=pc, combinational from the pc register.
  - The address holds stable while imem_ready=0.
  - ready=1, stall=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_INC; stays REQ. Back-to-back gives 1 instruction/cycle with zero-wait memory.
  - ready=0, stall=0: bubble; if_valid<=0, if_instr<=NOP_INSTR, if_pc holds.
  - stall=1: the if_* registers hold their values.
  - ready=1, stall=1: rdata and pc are captured into the hold buffer; pc<=pc+PC_INC; go to HOLD.
- HOLD:
  - imem_req=0.
  - stall=1: remain in HOLD, all outputs hold.
  - stall=0: buffer moves to if_*, if_valid<=1, buffer is cleared, go to REQ. The next request issues that same cycle the state is REQ, i.e. one cycle later.
- Redirect priority: redirect overrides everything except reset, and is taken regardless of stall or state.
  - pc<=branch_target with bit0 forced to 0.
  - if_valid<=0, if_instr<=NOP_INSTR.
  - Hold buffer is cleared.
  - Any imem response arriving in the same cycle is discarded.
  - Next state is REQ.
  - A request pending without ready is abandoned. The memory must tolerate an address change while req=1.
- Redirect from IDLE: pc is loaded with the target and the state goes to REQ.
- Arithmetic: pc+PC_INC is modulo 2^16, so 16'hFFFE wraps to 16'h0000 with no flag.
- branch=1 with pcsrc=1 is treated as sequential, identical to branch=0.
- pcsrc is ignored when branch=0 (the branch unit may hold a stale value).
- Output ordering: imem_req/imem_addr are combinational from state and pc. All if_* outputs and pc are registered.

Test Plan:
- Reset release, zero-wait memory returning 16'h1111, 16'h2222, 16'h3333 -> imem_addr 0,2,4 on successive cycles. if_valid rises 1 cycle after the first req, with if_pc=0, 2, 4.
- imem_ready low for 3 cycles at addr 4 -> imem_addr stays 4; three if_valid=0 bubbles with if_instr=NOP; then if_instr=rdata and if_pc=4.
- stall=1 for 2 cycles while ready=1 at addr 6 returning 16'hABCD:
  - During stall: if_* unchanged, HOLD entered, imem_req=0.
  - After stall drops: if_instr=16'hABCD, if_pc=6, and the next imem_addr is 8.
- branch=1, pcsrc=0, branch_target=16'h0041 while fetching addr 10 with ready=1:
  - Next cycle: if_valid=0, rdata discarded, pc=16'h0040.
  - The following cycle: imem_addr=16'h0040.
- Redirect in HOLD with stall=1 and target 16'h0100 -> buffer discarded, if_valid=0, next imem_addr=16'h0100. branch=1, pcsrc=1 instead -> no redirect, sequential fetch continues.
- Two cases:
  - pc=16'hFFFE fetched -> next pc=16'h0000.
  - reset_n pulsed low mid-HOLD -> immediately pc=RESET_PC, if_valid=0, imem_req=0; fetch resumes from 0.
